// File: rtl/ibus_arb.sv
// ibus_arb: two-requester instruction bus arbiter with starvation guard and 1-cycle read return
module ibus_arb #(
  parameter int DW = 16,
  parameter int AW = 16,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] ibus_addr,
  input  logic [DW-1:0] ibus_dout
);
  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} own_t;
  localparam logic [3:0] SMAX = 4'(STARVE);
  own_t owner, owner_nx;
  logic [3:0] starve, starve_nx;
  logic [AW-1:0] last_addr;
  always_comb begin
    m1_gnt = rst_n & m1_req & (~m0_req | (starve == SMAX));
    m0_gnt = rst_n & m0_req & ~m1_gnt;
    ibus_addr = m0_gnt ? m0_addr : m1_gnt ? m1_addr : last_addr;
    owner_nx = m0_gnt ? OWN_M0 : m1_gnt ? OWN_M1 : OWN_NONE;
    starve_nx = (m1_req & ~m1_gnt) ? ((starve == SMAX) ? starve : starve + 4'd1) : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
      starve <= 4'd0;
      last_addr <= '0;
    end else begin
      owner <= owner_nx;
      starve <= starve_nx;
      if (m0_gnt | m1_gnt) last_addr <= ibus_addr;
    end
  end
  // owner records last cycle's grant, so it marks whose data is on ibus_dout now
  assign m0_rvalid = (owner == OWN_M0);
  assign m1_rvalid = (owner == OWN_M1);
  assign m0_rdata = m0_rvalid ? ibus_dout : '0;
  assign m1_rdata = m1_rvalid ? ibus_dout : '0;
endmodule

// File: tb/tb_ibus_arb.sv
// tb_ibus_arb: directed + random checks of ibus_arb against a cycle-level reference model
module tb_ibus_arb;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int STARVE = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0, ibus_addr;
  logic [DW-1:0] ibus_dout = '0, m0_rdata, m1_rdata;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  int errors = 0, checks = 0;
  int wait_n = 0, p_who = 0;
  logic [AW-1:0] last = '0, p_addr = '0;
  logic seen1 = 1'b0;
  ibus_arb #(.DW(DW), .AW(AW), .STARVE(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ibus_addr(ibus_addr), .ibus_dout(ibus_dout)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {a[7:0], ~a[7:0]} ^ 16'h1234;
  endfunction
  // instruction memory: samples the address at the edge, returns data the next cycle
  always @(posedge clk) ibus_dout <= mem(ibus_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    wait_n = 0;
    p_who = 0;
    last = '0;
    p_addr = '0;
  endtask
  task automatic check_out(input logic e0, input logic e1, input logic [AW-1:0] ea);
    seen1 = m1_gnt;
    chk("m0_gnt", 32'(m0_gnt), 32'(e0));
    chk("m1_gnt", 32'(m1_gnt), 32'(e1));
    chk("ibus_addr", 32'(ibus_addr), 32'(ea));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(p_who == 1));
    chk("m0_rdata", 32'(m0_rdata), 32'(p_who == 1 ? mem(p_addr) : 16'h0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(p_who == 2));
    chk("m1_rdata", 32'(m1_rdata), 32'(p_who == 2 ? mem(p_addr) : 16'h0));
  endtask
  task automatic cyc(input logic r0, input logic [AW-1:0] a0, input logic r1, input logic [AW-1:0] a1);
    logic e0, e1;
    logic [AW-1:0] ea;
    @(negedge clk);
    m0_req = r0;
    m0_addr = a0;
    m1_req = r1;
    m1_addr = a1;
    #1;
    e1 = rst_n && r1 && (!r0 || wait_n == STARVE);
    e0 = rst_n && r0 && !e1;
    ea = e0 ? a0 : e1 ? a1 : last;
    check_out(e0, e1, ea);
    @(posedge clk);
    if (rst_n) begin
      p_who = e0 ? 1 : e1 ? 2 : 0;
      p_addr = ea;
      if (e0 || e1) last = ea;
      wait_n = (r1 && !e1) ? ((wait_n < STARVE) ? wait_n + 1 : STARVE) : 0;
    end
  endtask
  initial begin
    m0_req = 1'b1;
    m0_addr = 16'h0005;
    @(negedge clk);
    #1;
    check_out(1'b0, 1'b0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 16'h0005, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b1, AW'(i), 1'b0, '0);
    cyc(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, AW'(16'h10 + i), 1'b1, AW'(16'h20 + i));
      chk("starve_pattern", 32'(seen1), 32'(i % 5 == 4));
    end
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 16'h0041);
    repeat (4) cyc(1'b0, '0, 1'b0, '0);
    #1 chk("idle_hold", 32'(ibus_addr), 32'h41);
    cyc(1'b1, 16'h0002, 1'b0, '0);
    @(negedge clk);
    m0_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_out(1'b0, 1'b0, '0);
    @(negedge clk);
    #1 check_out(1'b0, 1'b0, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, '0, 1'b0, '0);
    cyc(1'b0, '0, 1'b1, 16'h0007);
    cyc(1'b0, '0, 1'b0, '0);
    repeat (400) cyc($urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)),
                     $urandom_range(0, 3) != 0, AW'($urandom_range(0, 15)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
